// File: rtl/vga_sync_gen.sv
// VGA raster timing generator (640x480@60 Hz by default) running from a
// 50 MHz clock with an internal 25 MHz pixel-enable tick.
// Optional feature: define VGA_FRAME_TICK_EN to add the frame_tick output,
// a one-clk pulse at the start of vertical blanking.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       clk,
  input  logic       reset_clk,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       hsync_next;
  logic       vsync_next;
  logic       video_on_next;

  // Next raster position: advance only on pixel-tick edges, wrapping x then y.
  always_comb begin
    x_next = pixel_x;
    y_next = pixel_y;
    if (pixel_tick) begin
      if (pixel_x == H_LAST) begin
        x_next = '0;
        if (pixel_y == V_LAST) begin
          y_next = '0;
        end else begin
          y_next = pixel_y + 10'd1;
        end
      end else begin
        x_next = pixel_x + 10'd1;
      end
    end
  end

  // Decode syncs and visibility from the next position so that the
  // registered outputs line up exactly with the registered counters.
  always_comb begin
    hsync_next    = !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
    vsync_next    = !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
    video_on_next = (x_next < H_VIS) && (y_next < V_VIS);
  end

  // Tick, counters and decoded outputs all update on the same edge.
  always_ff @(posedge clk or negedge reset_clk) begin
    if (!reset_clk) begin
      pixel_tick <= 1'b0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
    end else begin
      pixel_tick <= ~pixel_tick;
      pixel_x    <= x_next;
      pixel_y    <= y_next;
      hsync      <= hsync_next;
      vsync      <= vsync_next;
      video_on   <= video_on_next;
    end
  end

`ifdef VGA_FRAME_TICK_EN
  // Pulse only on the edge where (0, V_DISPLAY) is entered; the pair is then
  // held for a second cycle with pixel_tick low, which must not re-fire.
  always_ff @(posedge clk or negedge reset_clk) begin
    if (!reset_clk) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pixel_tick && (x_next == '0) && (y_next == V_VIS);
    end
  end
`endif

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA 640x480@60 Hz raster timing for the Pong display pipeline.
- Sits directly downstream of the 50 MHz clock divider: its clk input is the divider's 50 MHz output.
- Internally derives a 25 MHz pixel-enable tick.
- Drives hsync/vsync to the connector, and pixel coordinates plus video_on to the game renderer.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  input  1  50 MHz clock from the clock divider
- reset_clk  input  1  reset; asynchronous, active-low (0 = reset)
- pixel_tick  output  1  25 MHz enable; high every other clk cycle
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- video_on  output  1  high while (pixel_x, pixel_y) is in the visible region
- pixel_x  output  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  output  10  current vertical count, 0..V_TOTAL-1

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525)
  - Counters are 10 bits; parameter sets with totals > 1024 are unsupported.
- Reset (reset_clk=0, asynchronous assert):
  - pixel_tick=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=0.
- Reset release is sampled on the next rising clk edge. There is no synchronizer inside; the upstream reset is already synchronous to clk.
- pixel_tick:
  - Register toggled on every clk edge out of reset.
  - First edge after release drives it 1; it then alternates 0/1.
- Counter advance happens only on a clk edge where pixel_tick==1:
  - pixel_x increments.
  - If pixel_x==H_TOTAL-1: pixel_x wraps to 0 and pixel_y increments.
  - If pixel_y==V_TOTAL-1 at the same time: pixel_y wraps to 0.
  - pixel_x and pixel_y change in the same edge on a wrap.
- Decode (all registered):
  - hsync, vsync and video_on are computed from the next-state counter values and registered on the same edge as the counters.
  - This keeps them cycle-aligned with pixel_x/pixel_y, with zero skew.
  - hsync=0 iff H_DISPLAY+H_FP <= x <= H_DISPLAY+H_FP+H_SYNC-1 (656..751).
  - vsync=0 iff V_DISPLAY+V_FP <= y <= V_DISPLAY+V_FP+V_SYNC-1 (490..491).
  - video_on=1 iff x<H_DISPLAY and y<V_DISPLAY.
- First clk edge after reset release: counters stay (0,0) because pixel_tick was 0, and video_on becomes 1.
- Each (x,y) pair is held for exactly 2 clk cycles.
- Line period is 1600 clk cycles; frame period is 840000 clk cycles.
- Reset mid-frame: all outputs return to reset values immediately, without waiting for a clock. The raster restarts at (0,0) after release, with no partial-line carry-over.
- No inputs other than clk/reset, so no simultaneous-event cases beyond the combined x/y wrap above.

Optional Feature:
- Macro: VGA_FRAME_TICK_EN.
- When defined:
  - Adds output port frame_tick (1 bit, reset 0).
  - frame_tick is registered and high for exactly one clk cycle: the cycle in which pixel_x==0 and pixel_y==V_DISPLAY first appear (start of vertical blanking).
  - Used by game logic to update ball and paddle state once per frame.
  - Rate is 1 per 840000 clk cycles.
- When undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: hold reset_clk=0 for 5 clk cycles → pixel_tick=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=0. After release, pixel_tick toggles each cycle and video_on=1 from the first edge.
- Horizontal timing: run one line → hsync low for exactly 192 clk cycles, starting when pixel_x becomes 656; video_on falls when pixel_x becomes 640; line period is 1600 cycles.
- Line/frame wrap: at (799,524) with pixel_tick=1 → next edge gives (0,0) simultaneously, with video_on=1. At (799,10) → next edge gives (0,11).
- Vertical timing: run a full frame → vsync low for exactly 3200 clk cycles (lines 490–491); frame period is 840000 cycles; hsync continues during vsync.
- Reset mid-frame: assert reset_clk=0 asynchronously at (300,200) between clk edges → outputs go to reset values before the next edge; after release, the raster restarts at (0,0).
- With VGA_FRAME_TICK_EN: run 2 frames → frame_tick is a single-cycle pulse coinciding with (0,480), spaced 840000 cycles apart, and never high elsewhere.
